// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access pipeline stage driving a req/ack data port and registering writeback fields
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  input  logic [31:0] inPc,
  input  logic [31:0] inAluResult,
  input  logic [31:0] inWData,
  input  logic [1:0]  inMemAccessWidth,
  input  logic        inIsLoad,
  input  logic        inIsStore,
  input  logic        inIsLoadUnsigned,
  input  logic        inRdEn,
  input  logic [4:0]  inRdAddr,
  output logic        stall,
  output logic        dReq,
  output logic        dWe,
  output logic [31:0] dAddr,
  output logic [3:0]  dBe,
  output logic [31:0] dWData,
  input  logic        dAck,
  input  logic [31:0] dRData,
  output logic        wbValid,
  output logic [31:0] wbPc,
  output logic [31:0] wbData,
  output logic        wbRdEn,
  output logic [4:0]  wbRdAddr,
  output logic        misaligned,
  output logic        busErr
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, stateNext;
  logic [7:0] timer;
  logic isMem, misalign, accept, done, timeout;
  logic [3:0] be;
  logic [7:0] ldByte;
  logic [15:0] ldHalf;
  logic [31:0] storeData, loadData;
  always_comb begin
    isMem = inIsLoad | inIsStore;
    misalign = inMemAccessWidth == 2'd0 ? 1'b0 : inMemAccessWidth == 2'd1 ? inAluResult[0] : |inAluResult[1:0];
    accept = state == IDLE && inValid && isMem && !misalign;
    done = state == ACCESS && dAck;
    timeout = state == ACCESS && !dAck && timer == 8'(TIMEOUT_CYCLES - 1);
    stateNext = accept ? ACCESS : (done || timeout) ? IDLE : state;
    stall = rst && (accept || (state == ACCESS && !dAck && !timeout));
  end
  // Narrow stores are replicated across lanes; dBe picks the live ones.
  always_comb begin
    be = inMemAccessWidth == 2'd0 ? 4'b0001 << inAluResult[1:0] :
         inMemAccessWidth == 2'd1 ? (inAluResult[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    storeData = inMemAccessWidth == 2'd0 ? {4{inWData[7:0]}} :
                inMemAccessWidth == 2'd1 ? {2{inWData[15:0]}} : inWData;
    ldByte = dRData[{inAluResult[1:0], 3'b000} +: 8];
    ldHalf = inAluResult[1] ? dRData[31:16] : dRData[15:0];
    loadData = inMemAccessWidth == 2'd0 ? {{24{~inIsLoadUnsigned & ldByte[7]}}, ldByte} :
               inMemAccessWidth == 2'd1 ? {{16{~inIsLoadUnsigned & ldHalf[15]}}, ldHalf} : dRData;
  end
  always_ff @(negedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= stateNext;
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
      dReq <= 1'b0;
      dWe <= 1'b0;
      dAddr <= '0;
      dBe <= '0;
      dWData <= '0;
      wbValid <= 1'b0;
      wbPc <= '0;
      wbData <= '0;
      wbRdEn <= 1'b0;
      wbRdAddr <= '0;
      misaligned <= 1'b0;
      busErr <= 1'b0;
    end else begin
      wbValid <= 1'b0;
      misaligned <= 1'b0;
      busErr <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          timer <= '0;
          dReq <= 1'b1;
          dWe <= inIsStore;
          dAddr <= {inAluResult[31:2], 2'b00};
          dBe <= be;
          dWData <= storeData;
        end else if (inValid) begin
          wbValid <= 1'b1;
          wbPc <= inPc;
          wbData <= inAluResult;
          wbRdAddr <= inRdAddr;
          wbRdEn <= inRdEn && !(isMem && misalign);
          misaligned <= isMem && misalign;
        end
      end else if (done || timeout) begin
        dReq <= 1'b0;
        wbValid <= 1'b1;
        wbPc <= inPc;
        wbRdAddr <= inRdAddr;
        wbRdEn <= done && inRdEn;
        busErr <= timeout;
        wbData <= (done && !inIsStore) ? loadData : inAluResult;
      end else timer <= timer + 8'd1;
    end
  end
endmodule
